// File: rtl/blur_line_ctrl_pkg.sv
`default_nettype none
// blur_line_ctrl_pkg: shared constants, state encoding and ring-pointer helpers
// for the 5x5 blur line-buffer sequencer.  Rev 1.0
package blur_line_ctrl_pkg;
  localparam int LINE_W_DEF  = 640;
  localparam int FRAME_H_DEF = 480;
  localparam int NBUF        = 5;
  localparam int CNT_W       = 10;
  localparam int PTR_W       = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2
  } state_t;

  localparam logic [NBUF-1:0][NBUF-1:0] WE_ONEHOT = {
    5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001
  };

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NBUF - 1)) ? '0 : p + 1'b1;
  endfunction
endpackage
`default_nettype wire

// File: rtl/blur_pos_counter.sv
`default_nettype none
// blur_pos_counter: column/row position of the pixel being accepted, with
// line-end and frame-end strobes.  Rev 1.0
module blur_pos_counter
  import blur_line_ctrl_pkg::*;
#(
  parameter int LINE_W  = LINE_W_DEF,
  parameter int FRAME_H = FRAME_H_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_adv,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_col,
  output logic [CNT_W-1:0] o_row,
  output logic             o_line_end,
  output logic             o_frame_end
);
  logic [CNT_W-1:0] r_col;
  logic [CNT_W-1:0] r_row;

  // A restarting pixel is itself (0,0), so the clear acts on the current position.
  assign o_col       = i_clr ? '0 : r_col;
  assign o_row       = i_clr ? '0 : r_row;
  assign o_line_end  = (o_col == CNT_W'(LINE_W - 1));
  assign o_frame_end = o_line_end && (o_row == CNT_W'(FRAME_H - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_adv) begin
      if (o_line_end) begin
        r_col <= '0;
        r_row <= o_frame_end ? '0 : o_row + 1'b1;
      end else begin
        r_col <= o_col + 1'b1;
        r_row <= o_row;
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/blur_line_ctrl.sv
`default_nettype none
// blur_line_ctrl: pixel-stream sequencer driving the five-row buffer ring of a
// 5x5 blur kernel (write/read enables, oldest-row index, window valid).  Rev 1.0
module blur_line_ctrl
  import blur_line_ctrl_pkg::*;
#(
  parameter int LINE_W  = LINE_W_DEF,
  parameter int FRAME_H = FRAME_H_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             frame_start,
  input  logic             pix_valid,
  input  logic [7:0]       pix_data,
  output logic [7:0]       buf_data,
  output logic [NBUF-1:0]  buf_write_en,
  output logic             buf_read_en,
  output logic [PTR_W-1:0] row_sel,
  output logic             win_valid,
  output logic [CNT_W-1:0] col,
  output logic [CNT_W-1:0] row,
  output logic             busy
);
  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_restart;
  logic             w_read;
  logic             w_line_end;
  logic             w_frame_end;
  logic [CNT_W-1:0] w_col;
  logic [CNT_W-1:0] w_row;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] w_ptr;

  assign w_accept  = pix_valid & ((r_state != IDLE) | frame_start);
  assign w_restart = w_accept & frame_start;
  assign w_ptr     = w_restart ? '0 : r_wr_ptr;

  blur_pos_counter #(
    .LINE_W  (LINE_W),
    .FRAME_H (FRAME_H)
  ) u_pos (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_adv       (w_accept),
    .i_clr       (w_restart),
    .o_col       (w_col),
    .o_row       (w_row),
    .o_line_end  (w_line_end),
    .o_frame_end (w_frame_end)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_read      = 1'b0;
    if (w_restart) begin
      w_state_nxt = FILL;
    end else if (w_accept) begin
      case (r_state)
        FILL:    if (w_line_end && (w_row == CNT_W'(3))) w_state_nxt = STREAM;
        STREAM: begin
          w_read = 1'b1;
          if (w_frame_end) w_state_nxt = IDLE;
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Strobes clear on idle cycles; position and oldest-row index hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr     <= '0;
      buf_data     <= '0;
      buf_write_en <= '0;
      buf_read_en  <= 1'b0;
      win_valid    <= 1'b0;
      row_sel      <= '0;
      col          <= '0;
      row          <= '0;
      busy         <= 1'b0;
    end else begin
      busy         <= (w_state_nxt != IDLE);
      buf_write_en <= '0;
      buf_read_en  <= 1'b0;
      win_valid    <= 1'b0;
      if (w_accept) begin
        buf_data     <= pix_data;
        buf_write_en <= WE_ONEHOT[w_ptr];
        buf_read_en  <= w_read;
        win_valid    <= w_read && (w_col >= CNT_W'(4));
        row_sel      <= ptr_inc(w_ptr);
        col          <= w_col;
        row          <= w_row;
        r_wr_ptr     <= w_line_end ? ptr_inc(w_ptr) : w_ptr;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_blur_line_ctrl.sv
`default_nettype none
// tb_blur_line_ctrl: self-checking bench for blur_line_ctrl on a reduced
// 16x10 frame, against a pixel-index reference model.  Rev 1.0
module tb_blur_line_ctrl;
  localparam int LW = 16;
  localparam int FH = 10;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_start = 1'b0;
  logic       pix_valid = 1'b0;
  logic [7:0] pix_data = 8'h00;
  logic [7:0] buf_data;
  logic [4:0] buf_write_en;
  logic       buf_read_en;
  logic [2:0] row_sel;
  logic       win_valid;
  logic [9:0] col;
  logic [9:0] row;
  logic       busy;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: frame position derived from the pixel index in the frame.
  bit         m_active = 1'b0;
  int         m_n = 0;
  int         m_col = 0;
  int         m_row = 0;
  int         m_sel = 0;
  logic [7:0] m_data = 8'h00;

  blur_line_ctrl #(.LINE_W(LW), .FRAME_H(FH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .frame_start  (frame_start),
    .pix_valid    (pix_valid),
    .pix_data     (pix_data),
    .buf_data     (buf_data),
    .buf_write_en (buf_write_en),
    .buf_read_en  (buf_read_en),
    .row_sel      (row_sel),
    .win_valid    (win_valid),
    .col          (col),
    .row          (row),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " buf_data"},     32'(buf_data), 0);
    chk({tag, " buf_write_en"}, 32'(buf_write_en), 0);
    chk({tag, " buf_read_en"},  32'(buf_read_en), 0);
    chk({tag, " row_sel"},      32'(row_sel), 0);
    chk({tag, " win_valid"},    32'(win_valid), 0);
    chk({tag, " col"},          32'(col), 0);
    chk({tag, " row"},          32'(row), 0);
    chk({tag, " busy"},         32'(busy), 0);
  endtask

  task automatic step(input bit fs, input bit pv, input logic [7:0] d);
    bit         acc;
    int         x;
    int         y;
    logic [4:0] e_we;
    bit         e_re;
    bit         e_win;
    @(negedge clk);
    frame_start = fs;
    pix_valid   = pv;
    pix_data    = d;
    acc   = pv && (m_active || fs);
    e_we  = '0;
    e_re  = 1'b0;
    e_win = 1'b0;
    if (acc) begin
      if (fs) m_n = 0;
      x     = m_n % LW;
      y     = m_n / LW;
      e_we  = 5'(1 << (y % 5));
      e_re  = !fs && (y >= 4);
      e_win = e_re && (x >= 4);
      m_col = x;
      m_row = y;
      m_sel = (y + 1) % 5;
      m_data = d;
      m_n++;
      m_active = (m_n < LW * FH);
    end
    @(posedge clk);
    #1;
    if (acc) chk("buf_data", 32'(buf_data), 32'(m_data));
    chk("buf_write_en", 32'(buf_write_en), 32'(e_we));
    chk("buf_read_en",  32'(buf_read_en), 32'(e_re));
    chk("win_valid",    32'(win_valid), 32'(e_win));
    chk("col",          32'(col), m_col);
    chk("row",          32'(row), m_row);
    chk("row_sel",      32'(row_sel), m_sel);
    chk("busy",         32'(busy), 32'(m_active));
  endtask

  typedef struct {
    bit         fs;
    bit         pv;
    logic [7:0] d;
    logic [4:0] we;
    bit         re;
    int         col;
    int         row;
    int         sel;
    bit         busy;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{1'b0, 1'b1, 8'h11, 5'b00000, 1'b0, 0, 0, 0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 8'h22, 5'b00000, 1'b0, 0, 0, 0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 8'h33, 5'b00001, 1'b0, 0, 0, 1, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 8'h44, 5'b00001, 1'b0, 1, 0, 1, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 8'h55, 5'b00000, 1'b0, 1, 0, 1, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 8'h66, 5'b00001, 1'b0, 2, 0, 1, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 8'h77, 5'b00001, 1'b0, 0, 0, 1, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 8'h88, 5'b00001, 1'b0, 1, 0, 1, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      frame_start = tbl[i].fs;
      pix_valid   = tbl[i].pv;
      pix_data    = tbl[i].d;
      @(posedge clk);
      #1;
      if (tbl[i].we != 5'b0) chk("tbl buf_data", 32'(buf_data), 32'(tbl[i].d));
      chk("tbl buf_write_en", 32'(buf_write_en), 32'(tbl[i].we));
      chk("tbl buf_read_en",  32'(buf_read_en), 32'(tbl[i].re));
      chk("tbl col",          32'(col), tbl[i].col);
      chk("tbl row",          32'(row), tbl[i].row);
      chk("tbl row_sel",      32'(row_sel), tbl[i].sel);
      chk("tbl busy",         32'(busy), 32'(tbl[i].busy));
    end
    m_active = 1'b1;
    m_n      = 2;
    m_col    = 1;
    m_row    = 0;
    m_sel    = 1;
    m_data   = 8'h88;

    // Asynchronous reset in mid-line
    while (m_n < 10) step(1'b0, 1'b1, 8'($urandom));
    @(negedge clk);
    pix_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("async reset");
    m_active = 1'b0;
    m_n = 0; m_col = 0; m_row = 0; m_sel = 0; m_data = 8'h00;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) step(1'b0, 1'b1, 8'($urandom));
    chk("post-reset no write", 32'(buf_write_en), 0);

    // Fill rows 0-3, then stream onset in row 4
    step(1'b1, 1'b1, 8'($urandom));
    repeat (4 * LW - 1) step(1'b0, 1'b1, 8'($urandom));
    chk("fill read_en low", 32'(buf_read_en), 0);
    for (int i = 0; i < LW; i++) begin
      step(1'b0, 1'b1, 8'($urandom));
      if (i == 0) begin
        chk("row4 write_en", 32'(buf_write_en), 32'h10);
        chk("row4 read_en",  32'(buf_read_en), 1);
        chk("row4 row_sel",  32'(row_sel), 0);
        chk("row4 win col0", 32'(win_valid), 0);
      end
      if (i == 3) chk("row4 win col3", 32'(win_valid), 0);
      if (i == 4) chk("row4 win col4", 32'(win_valid), 1);
    end
    step(1'b0, 1'b1, 8'($urandom));
    chk("row5 write_en", 32'(buf_write_en), 32'h01);
    chk("row5 row_sel",  32'(row_sel), 1);
    repeat (LW - 1) step(1'b0, 1'b1, 8'($urandom));

    // Stall pattern 1-0-0-1 in row 6
    repeat (3) step(1'b0, 1'b1, 8'($urandom));
    step(1'b0, 1'b1, 8'($urandom));
    step(1'b0, 1'b0, 8'($urandom));
    chk("stall write_en", 32'(buf_write_en), 0);
    chk("stall col hold", 32'(col), 3);
    step(1'b0, 1'b0, 8'($urandom));
    step(1'b0, 1'b1, 8'($urandom));
    chk("stall resume col", 32'(col), 4);

    // Run to frame end
    for (int k = 0; k < LW * FH && m_active; k++) step(1'b0, 1'b1, 8'($urandom));
    chk("last col", 32'(col), LW - 1);
    chk("last row", 32'(row), FH - 1);
    chk("frame end busy", 32'(busy), 0);
    repeat (3) step(1'b0, 1'b1, 8'($urandom));
    chk("after end no write", 32'(buf_write_en), 0);

    // Restart mid-frame at (8,6)
    step(1'b1, 1'b1, 8'($urandom));
    while (m_n < 6 * LW + 8) step(1'b0, 1'b1, 8'($urandom));
    step(1'b1, 1'b1, 8'h5a);
    chk("restart col",      32'(col), 0);
    chk("restart row",      32'(row), 0);
    chk("restart write_en", 32'(buf_write_en), 32'h01);
    chk("restart read_en",  32'(buf_read_en), 0);
    chk("restart busy",     32'(busy), 1);
    repeat (4 * LW) step(1'b0, 1'b1, 8'($urandom));

    // Randomized traffic
    repeat (3000) step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7, 8'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
